pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline control unit that drives the `en` (hold) and `R` (synchronous clear) inputs of every inter-stage `latch` and the PC register. It is the control-side counterpart of the latch interface. It detects load-use hazards, EX-stage redirects, data-memory wait and multi-cycle EX operations, and converts them into per-boundary stall and bubble/flush commands. It sits beside the datapath and drives the IF/ID, ID/EX, EX/MEM and MEM/WB latches.

## Interface
- `MC_LAT`, 4: EX occupancy in cycles of a multi-cycle op; must be ≥2.
- `REG_ADDR_BITS`, 5: register index width.
- `PERF_BITS`, 32: width of the perf counters.

- `clk` in 1: single clock; all state updates on posedge.
- `R_n` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in REG_ADDR_BITS: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads rs1 / rs2.
- `ex_is_load` in 1: EX holds a load.
- `ex_rd` in REG_ADDR_BITS: EX destination register.
- `ex_redirect` in 1: EX resolved a taken or mispredicted control transfer (one-cycle pulse).
- `ex_mc_start` in 1: EX holds a multi-cycle op that entered EX this cycle.
- `mem_busy` in 1: data memory is not ready; level signal.
- `pc_en` out 1: PC register enable.
- `en_if_id`, `en_id_ex`, `en_ex_mem`, `en_mem_wb` out 1: latch enables.
- `R_if_id`, `R_id_ex`, `R_ex_mem`, `R_mem_wb` out 1: latch synchronous clears.
- `perf_stall_cnt`, `perf_flush_cnt` out PERF_BITS: present only with `PIPE_CTRL_PERF_EN`.

## Operation
- State machine with two states:
  - `RUN`.
  - `MC_BUSY`: holds a down-counter `mc_cnt` of width clog2(MC_LAT).
- Extra register `redir_pend`: a redirect captured while frozen.
- Outputs are combinational from registered state and current inputs. They take effect at the next posedge, matching latch semantics where `R` has priority over `en`.
- Default in `RUN`: all `en`=1, all `R`=0, `pc_en`=1.
- Priority, highest first:
  - **mem_busy:** all `en`=0, `pc_en`=0, all `R`=0 (full freeze).
    - If `ex_redirect`=1 in the same cycle, set `redir_pend`.
    - The FSM counter does not advance.
  - **Redirect:** `ex_redirect` or `redir_pend`, with `mem_busy`=0.
    - `R_if_id`=1, `R_id_ex`=1, `pc_en`=1.
    - Clear `redir_pend`.
    - Overrides load-use.
  - **MC start:** in `RUN` with `ex_mc_start`=1.
    - Go to `MC_BUSY` with `mc_cnt`=MC_LAT-2.
    - This cycle: `pc_en`=0, `en_if_id`=0, `en_id_ex`=0, `R_ex_mem`=1 (bubble).
  - **MC_BUSY:**
    - While `mc_cnt`≠0, same outputs as MC start; decrement.
    - When `mc_cnt`=0, `RUN` defaults apply, EX/MEM captures the result, and the next state is `RUN`.
    - `ex_redirect` and `ex_mc_start` are ignored in this state.
  - **Load-use:** in `RUN`, when `ex_is_load` and `ex_rd`≠0 and (`id_use_rs1` and `id_rs1`=`ex_rd`, or `id_use_rs2` and `id_rs2`=`ex_rd`).
    - `pc_en`=0, `en_if_id`=0, `R_id_ex`=1.
    - Exactly one bubble is inserted.
- x0 never creates a hazard.

## Timing
- While `R_n`=0: state=`RUN`, `mc_cnt`=0, `redir_pend`=0, perf counters=0.
  - Outputs forced to all `en`=0, `pc_en`=0, all `R`=1.
- Reset asserted mid-`MC_BUSY` aborts the op immediately.
- Zero-cycle decision latency: hazard inputs in cycle N affect the latches at the end of cycle N.
- Multi-cycle op: EX/MEM is bubbled for MC_LAT-1 cycles, then loads the result on the MC_LAT-th edge.
- A pending redirect is applied in the first cycle with `mem_busy`=0.
- Perf counters:
  - `perf_stall_cnt` increments every cycle with `pc_en`=0 and `R_n`=1.
  - `perf_flush_cnt` increments on each applied redirect.
  - Both wrap modulo 2^PERF_BITS.

## Configuration
- `PIPE_CTRL_PERF_EN`:
  - Defined: the perf counters and ports exist.
  - Undefined: ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - `pc_state_t` enum (`RUN`, `MC_BUSY`).
  - A struct bundling one boundary's `{en, R}` pair.
  - Latch-boundary index constants.
- `DWORD_BITS` stays in `defines.sv`.
- One sub-module, `mc_counter`: load / decrement / zero-flag down-counter with async reset.

## Test plan
- Reset: hold `R_n`=0 for 3 cycles → all `R`=1, all `en`=0, `pc_en`=0. Release → `RUN` defaults next cycle.
- Load-use: `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → exactly one cycle of `pc_en`=0, `en_if_id`=0, `R_id_ex`=1. Same stimulus with `ex_rd`=0 → no stall.
- Redirect plus load-use in the same cycle → `R_if_id`=`R_id_ex`=1, `pc_en`=1, no stall.
- MC op with MC_LAT=4: `ex_mc_start` pulse → `R_ex_mem`=1 for 3 cycles, `en_ex_mem` load on the 4th edge, back to `RUN`.
- `mem_busy` high for 5 cycles with an `ex_redirect` pulse in cycle 2 → full freeze for 5 cycles, then the flush is applied in cycle 6. With `PIPE_CTRL_PERF_EN`: `perf_stall_cnt`=5, `perf_flush_cnt`=1.
- `R_n` dropped in the 2nd `MC_BUSY` cycle → state `RUN`, counter 0 immediately. No EX/MEM load after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline control unit.
//   pc_state_t   - controller FSM state (RUN / MC_BUSY)
//   latch_ctrl_t - one latch boundary's {en, r} command pair
//   Bnd*         - latch-boundary indices into a latch_ctrl_t vector
// DWORD_BITS is intentionally not defined here; it lives in defines.sv.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } pc_state_t;

    // r has priority over en inside the latch, so {en:1, r:1} still clears.
    typedef struct packed {
        logic en;
        logic r;
    } latch_ctrl_t;

    localparam int unsigned BndIfId  = 0;
    localparam int unsigned BndIdEx  = 1;
    localparam int unsigned BndExMem = 2;
    localparam int unsigned BndMemWb = 3;
    localparam int unsigned NumBnd   = 4;

    function automatic latch_ctrl_t lc(input logic en, input logic r);
        latch_ctrl_t c;
        c.en = en;
        c.r  = r;
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs from the datapath and latch/PC commands back to it.
//   master modport - the control unit (reads hazard info, drives en/R/pc_en)
//   slave modport  - the datapath side (drives hazard info, reads en/R/pc_en)
interface pipe_ctrl_if #(
    parameter int unsigned REG_ADDR_BITS = 5
);
    logic [REG_ADDR_BITS-1:0] id_rs1;
    logic [REG_ADDR_BITS-1:0] id_rs2;
    logic                     id_use_rs1;
    logic                     id_use_rs2;
    logic                     ex_is_load;
    logic [REG_ADDR_BITS-1:0] ex_rd;
    logic                     ex_redirect;
    logic                     ex_mc_start;
    logic                     mem_busy;

    logic pc_en;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic R_if_id;
    logic R_id_ex;
    logic R_ex_mem;
    logic R_mem_wb;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
        input  ex_redirect, ex_mc_start, mem_busy,
        output pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
        output R_if_id, R_id_ex, R_ex_mem, R_mem_wb
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
        output ex_redirect, ex_mc_start, mem_busy,
        input  pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
        input  R_if_id, R_id_ex, R_ex_mem, R_mem_wb
    );

endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// mc_counter: down-counter tracking the remaining bubble cycles of a multi-cycle EX op.
//   clk, R_n   - clock, asynchronous active-low reset (count -> 0)
//   load_i     - load load_val_i (wins over dec_i)
//   dec_i      - decrement; saturates at zero
//   zero_o     - count is zero
module mc_counter #(
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             R_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit driving the en/R pair of each inter-stage latch
// and the PC enable. Resolves, in priority order: data-memory wait (full freeze),
// EX redirect (flush IF/ID and ID/EX), multi-cycle EX op (hold front, bubble EX/MEM),
// and load-use (hold front, bubble ID/EX).
//   clk, R_n            - clock, asynchronous active-low reset
//   bus (master)        - hazard inputs and latch/PC commands, see pipe_ctrl_if
//   perf_stall_cnt      - cycles with pc_en=0 out of reset   (PIPE_CTRL_PERF_EN only)
//   perf_flush_cnt      - applied redirects                  (PIPE_CTRL_PERF_EN only)
// Optional feature macro: PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LAT        = 4,
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned PERF_BITS     = 32
) (
    input  logic                 clk,
    input  logic                 R_n,
`ifdef PIPE_CTRL_PERF_EN
    output logic [PERF_BITS-1:0] perf_stall_cnt,
    output logic [PERF_BITS-1:0] perf_flush_cnt,
`endif
    pipe_ctrl_if.master          bus
);

    localparam int unsigned CntW = $clog2(MC_LAT);

    pc_state_t                 state_q, state_d;
    logic                      redir_pend_q, redir_pend_d;
    latch_ctrl_t [NumBnd-1:0]  bnd;
    logic                      pc_en;
    logic                      hazard;
    logic                      redir_req;
    logic                      redir_apply;
    logic                      mc_load;
    logic                      mc_dec;
    logic                      mc_zero;

    mc_counter #(
        .Width (CntW)
    ) u_mc_counter (
        .clk        (clk),
        .R_n        (R_n),
        .load_i     (mc_load),
        .load_val_i (CntW'(MC_LAT - 2)),
        .dec_i      (mc_dec),
        .zero_o     (mc_zero)
    );

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = bus.ex_is_load && (bus.ex_rd != '0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    assign redir_req = bus.ex_redirect || redir_pend_q;

    always_comb begin
        bnd          = {NumBnd{lc(1'b1, 1'b0)}};
        pc_en        = 1'b1;
        state_d      = state_q;
        redir_pend_d = redir_pend_q;
        redir_apply  = 1'b0;
        mc_load      = 1'b0;
        mc_dec       = 1'b0;

        if (!R_n) begin
            bnd   = {NumBnd{lc(1'b0, 1'b1)}};
            pc_en = 1'b0;
        end else if (bus.mem_busy) begin
            bnd   = {NumBnd{lc(1'b0, 1'b0)}};
            pc_en = 1'b0;
            // Redirects are ignored during a multi-cycle op, frozen or not.
            if ((state_q == RUN) && bus.ex_redirect) begin
                redir_pend_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (redir_req) begin
                        bnd[BndIfId] = lc(1'b1, 1'b1);
                        bnd[BndIdEx] = lc(1'b1, 1'b1);
                        redir_pend_d = 1'b0;
                        redir_apply  = 1'b1;
                    end else if (bus.ex_mc_start) begin
                        pc_en         = 1'b0;
                        bnd[BndIfId]  = lc(1'b0, 1'b0);
                        bnd[BndIdEx]  = lc(1'b0, 1'b0);
                        bnd[BndExMem] = lc(1'b1, 1'b1);
                        mc_load       = 1'b1;
                        state_d       = MC_BUSY;
                    end else if (hazard) begin
                        pc_en        = 1'b0;
                        bnd[BndIfId] = lc(1'b0, 1'b0);
                        bnd[BndIdEx] = lc(1'b1, 1'b1);
                    end
                end
                MC_BUSY: begin
                    if (!mc_zero) begin
                        pc_en         = 1'b0;
                        bnd[BndIfId]  = lc(1'b0, 1'b0);
                        bnd[BndIdEx]  = lc(1'b0, 1'b0);
                        bnd[BndExMem] = lc(1'b1, 1'b1);
                        mc_dec        = 1'b1;
                    end else begin
                        // Last cycle: RUN defaults let EX/MEM capture the result.
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_q      <= RUN;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    assign bus.pc_en     = pc_en;
    assign bus.en_if_id  = bnd[BndIfId].en;
    assign bus.en_id_ex  = bnd[BndIdEx].en;
    assign bus.en_ex_mem = bnd[BndExMem].en;
    assign bus.en_mem_wb = bnd[BndMemWb].en;
    assign bus.R_if_id   = bnd[BndIfId].r;
    assign bus.R_id_ex   = bnd[BndIdEx].r;
    assign bus.R_ex_mem  = bnd[BndExMem].r;
    assign bus.R_mem_wb  = bnd[BndMemWb].r;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_BITS-1:0] stall_cnt_q, flush_cnt_q;

    // Counters sit in reset while R_n=0, so pc_en=0 during reset is not counted.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt_q <= stall_cnt_q + PERF_BITS'(1);
            end
            if (redir_apply) begin
                flush_cnt_q <= flush_cnt_q + PERF_BITS'(1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
